// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared constants for the MiniCPU instruction memory.
//                Holds the NOP encoding, the opcode field values and the
//                boot program that imem_fetch loads at reset when the
//                IMEM_BOOT_PROG_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // All-zero word; out-of-range fetches return this.
    localparam logic [7:0] c_nop = 8'h00;

    // Opcode field values held in the upper nibble of an instruction.
    localparam logic [3:0] c_op_load_a     = 4'h1;
    localparam logic [3:0] c_op_load_b     = 4'h2;
    localparam logic [3:0] c_op_add        = 4'h4;
    localparam logic [3:0] c_op_or         = 4'h6;
    localparam logic [3:0] c_op_store_or   = 4'h7;
    localparam logic [3:0] c_op_store      = 4'h8;
    localparam logic [3:0] c_op_store_halt = 4'hC;

    // Boot program, 8 bits per word, zero-extended to IW when loaded.
    localparam int         c_boot_len = 12;
    localparam logic [7:0] c_boot_prog [c_boot_len] = '{
        8'h13, 8'h25, 8'h40, 8'hC0,
        8'h12, 8'h25, 8'h60, 8'h80,
        8'h14, 8'h21, 8'h70, 8'hC0
    };

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : imem_rsp_fifo
//  Description : Three-entry synchronous response FIFO with push, pop,
//                flush and occupancy count. The caller guarantees no push
//                when full and no pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_rsp_fifo #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    localparam logic [1:0] c_last = 2'd2;

    logic [W-1:0] r_mem [3];
    logic [1:0]   r_rd_ptr;
    logic [1:0]   r_wr_ptr;
    logic [1:0]   r_count;

    // Entry storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? 2'd0 : r_wr_ptr + 2'd1;
            end
            if (pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? 2'd0 : r_rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : imem_rsp_fifo
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch
//  Description : Programmable instruction memory for the MiniCPU fetch path.
//                Synchronous-read array, one registered read stage (S1),
//                a 3-entry response FIFO, program-load write port, flush
//                and out-of-range detection.
//                Build option: IMEM_BOOT_PROG_EN - when defined, reset loads
//                the boot program into the array; otherwise the array has no
//                reset and holds whatever the program port wrote.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch
    import imem_pkg::*;
#(
    parameter int IW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [IW-1:0] rsp_instr,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_err,
    input  logic          flush,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data
);

    localparam int          c_idxw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_depth    = (AW + 1)'(DEPTH);
    localparam int          c_ew       = IW + AW + 1;
    localparam logic [IW-1:0] c_nop_word = IW'(c_nop);

    // Instruction array
    logic [IW-1:0] r_mem [DEPTH];

    // Read stage S1
    logic          r_s1_v;
    logic [IW-1:0] r_s1_instr;
    logic [AW-1:0] r_s1_addr;
    logic          r_s1_err;

    logic              w_accept;
    logic              w_req_in_range;
    logic              w_prog_hit;
    logic [c_idxw-1:0] w_req_idx;
    logic [c_idxw-1:0] w_prog_idx;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic [c_ew-1:0]   w_fifo_head;
    logic [1:0]        w_fifo_count;
    logic              w_rsp_valid;

    assign w_req_in_range = ({1'b0, req_addr} < c_depth);
    assign w_prog_hit     = prog_we && ({1'b0, prog_addr} < c_depth);
    assign w_req_idx      = req_addr[c_idxw-1:0];
    assign w_prog_idx     = prog_addr[c_idxw-1:0];

    // Occupancy counts S1 as well, so the FIFO always has room for whatever
    // is in flight; rsp_ready is deliberately not part of this term.
    assign req_ready = !rst && (({1'b0, w_fifo_count} + {2'b00, r_s1_v}) < 3'd3);
    assign w_accept  = req_valid && req_ready;

`ifdef IMEM_BOOT_PROG_EN
    // Boot word i: program byte zero-extended, NOP beyond the program.
    function automatic logic [IW-1:0] boot_word(input int i);
        logic [IW-1:0] w_word;
        w_word = c_nop_word;
        if (i < c_boot_len) begin
            w_word = IW'(c_boot_prog[i]);
        end
        return w_word;
    endfunction

    // Array write port; reset reloads the boot image and blocks writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= boot_word(i);
            end
        end else if (w_prog_hit) begin
            r_mem[w_prog_idx] <= prog_data;
        end
    end
`else
    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_prog_hit) begin
            r_mem[w_prog_idx] <= prog_data;
        end
    end
`endif

    // S1 captures the array word (old data on a same-cycle write) or a NOP
    // with err for out-of-range addresses. An accept during flush survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_instr <= '0;
            r_s1_addr  <= '0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_instr <= w_req_in_range ? r_mem[w_req_idx] : c_nop_word;
                r_s1_addr  <= req_addr;
                r_s1_err   <= !w_req_in_range;
            end
        end
    end

    // S1 content is discarded on flush rather than pushed.
    assign w_fifo_push = r_s1_v && !flush;
    assign w_fifo_pop  = w_rsp_valid && rsp_ready;

    imem_rsp_fifo #(
        .W (c_ew)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_fifo_push),
        .push_data ({r_s1_err, r_s1_addr, r_s1_instr}),
        .pop       (w_fifo_pop),
        .flush     (flush),
        .head      (w_fifo_head),
        .count     (w_fifo_count)
    );

    // Outputs read as zero whenever the FIFO is empty, which also gives the
    // required all-zero values straight after reset.
    assign w_rsp_valid = (w_fifo_count != 2'd0);
    assign rsp_valid   = w_rsp_valid;
    assign rsp_instr   = w_rsp_valid ? w_fifo_head[IW-1:0]        : '0;
    assign rsp_addr    = w_rsp_valid ? w_fifo_head[IW+AW-1:IW]    : '0;
    assign rsp_err     = w_rsp_valid ? w_fifo_head[IW+AW]         : 1'b0;

endmodule : imem_fetch
`default_nettype wire
